// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO result stage for a sequential multiplier with stalling mfhi/mflo/mthi/mtlo and a timeout.
// Define MADD_EN to build the multiply-accumulate adder.
module hilo_unit #(
  parameter int LATENCY = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MulReq,
  input  logic        Acc,
  output logic        MulAck,
  output logic        MulStart,
  input  logic        ProdValid,
  input  logic [63:0] Product,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WrData,
  input  logic        RdHi,
  input  logic        RdLo,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic        Stall,
  output logic        Busy,
  output logic        Timeout,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);
  typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;
  localparam logic [6:0] CNT_MAX = 7'(LATENCY - 1);
  state_t      r_state, w_next;
  logic [6:0]  r_cnt;
  logic [63:0] r_hold, w_wr;
  logic [31:0] r_hi, r_lo, r_rd_data;
  logic        r_rd_valid, r_mul_start, r_timeout, w_tmo, w_rd;
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE:  w_next = MulReq ? START : IDLE;
      START: w_next = WAIT;
      WAIT: begin
        w_tmo  = !ProdValid && r_cnt == CNT_MAX;
        w_next = ProdValid ? WRITE : w_tmo ? IDLE : WAIT;
      end
      WRITE: w_next = IDLE;
    endcase
  end
  assign Busy     = r_state != IDLE;
  assign MulAck   = r_state == IDLE && MulReq;
  assign Stall    = Busy && (RdHi || RdLo || MtHi || MtLo);
  assign w_rd     = !Busy && (RdHi || RdLo);
  assign MulStart = r_mul_start;
  assign Timeout  = r_timeout;
  assign RdData   = r_rd_data;
  assign RdValid  = r_rd_valid;
  assign Hi       = r_hi;
  assign Lo       = r_lo;
`ifdef MADD_EN
  logic r_acc;
  always_ff @(posedge CLK) begin
    if (RST) r_acc <= 1'b0;
    else if (MulAck) r_acc <= Acc;
  end
  assign w_wr = r_acc ? {r_hi, r_lo} + r_hold : r_hold;
`else
  logic w_unused_acc;
  assign w_unused_acc = Acc;
  assign w_wr = r_hold;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_mul_start <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mul_start <= MulAck;
      r_rd_valid  <= w_rd;
      if (w_tmo) r_timeout <= 1'b1;
      if (r_state == START) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 7'd1;
      if (r_state == WAIT && ProdValid) r_hold <= Product;
      // read samples the pre-move value, so a same-cycle move is not visible
      if (w_rd) r_rd_data <= RdHi ? r_hi : r_lo;
      if (r_state == WRITE) {r_hi, r_lo} <= w_wr;
      else if (!Busy) begin
        if (MtHi) r_hi <= WrData;
        if (MtLo) r_lo <= WrData;
      end
    end
  end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO result stage that sits directly downstream of the sequential Booth multiplier in the MIPS ALU. Accepts multiply requests from decode, launches the multiplier, captures its 64-bit product into the architectural HI/LO registers, and serves `mfhi`/`mflo`/`mthi`/`mtlo`. Stalls the pipeline on HI/LO accesses while a multiply is in flight and flags a timeout if the multiplier never reports completion.

## Interface
- `LATENCY`, default 64, is the maximum cycles in WAIT before timeout. It covers 32 Booth iterations × 2 phases.
- `CLK`, input, 1 bit: sole clock, rising edge.
- `RST`, input, 1 bit: synchronous, active-high reset.
- `MulReq`, input, 1 bit: decode requests a multiply; held until `MulAck`.
- `Acc`, input, 1 bit: request is multiply-accumulate; honoured only with `MADD_EN`.
- `MulAck`, output, 1 bit: request accepted; combinational, high in IDLE when `MulReq`=1.
- `MulStart`, output, 1 bit: one-cycle registered pulse telling the multiplier to load A/B and begin.
- `ProdValid`, input, 1 bit: multiplier product is stable.
- `Product`, input, 64 bits: multiplier `Out`.
- `MtHi`, input, 1 bit: write `WrData` to HI.
- `MtLo`, input, 1 bit: write `WrData` to LO.
- `WrData`, input, 32 bits: data for `MtHi`/`MtLo`.
- `RdHi`, input, 1 bit: read HI.
- `RdLo`, input, 1 bit: read LO.
- `RdData`, output, 32 bits: registered read data.
- `RdValid`, output, 1 bit: `RdData` is valid this cycle.
- `Stall`, output, 1 bit: combinational; an HI/LO access is blocked by `Busy`.
- `Busy`, output, 1 bit: state ≠ IDLE.
- `Timeout`, output, 1 bit: sticky; multiplier exceeded `LATENCY`.
- `Hi`, output, 32 bits: HI register.
- `Lo`, output, 32 bits: LO register.

## Operation
- **States:** IDLE, START, WAIT, WRITE. Encoding is free.
- **IDLE:**
  - `MulReq`=1 → START and `MulAck`=1 this cycle.
  - Otherwise stay in IDLE.
- **START:**
  - `MulStart`=1 for exactly this cycle.
  - 7-bit cycle counter cleared to 0.
  - Go to WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - `ProdValid`=1 → latch `Product` into a 64-bit holding register, go to WRITE.
  - Otherwise, counter == `LATENCY`-1 → set `Timeout`, go to IDLE, HI/LO unchanged.
  - `ProdValid` takes priority over timeout in the same cycle.
- **WRITE:**
  - `{Hi,Lo}` ← holding register. With `MADD_EN` and a latched `Acc`, the sum applies instead (see Configuration).
  - Go to IDLE.
- **Arithmetic:**
  - Product is taken as a two's-complement 64-bit value.
  - Accumulate is a 64-bit add, modulo 2^64. No overflow flag.
- **Moves:**
  - Applied at the clock edge only when `Busy`=0.
  - `MtHi` and `MtLo` may be asserted together; both are written.
  - A move in IDLE in the same cycle as an accepted `MulReq` is performed; the later product overwrites it.
- **Reads:**
  - Accepted when `Busy`=0. `RdData` and `RdValid` are registered.
  - `RdHi` has priority over `RdLo` if both are high.
  - Read and move to the same register in one cycle: the read returns the old value.
- **Stall:** `Stall` = `Busy` & (`RdHi`|`RdLo`|`MtHi`|`MtLo`). A stalled access has no effect; the requester holds it.
- **Timeout:** cleared only by `RST`. A further `MulReq` is still accepted.

## Timing
- **Reset values:**
  - State IDLE.
  - `Hi`, `Lo`, `RdData` = 0.
  - `RdValid`, `MulStart`, `Timeout`, `Busy` = 0.
  - Counter = 0.
- **Reset mid-operation:** a reset in any state returns to IDLE next cycle, drops `MulStart`, and discards the held product.
- **Multiply sequence:**
  - `MulReq` accepted in cycle 0.
  - `MulStart` is high in cycle 1.
  - WAIT begins in cycle 2.
  - `ProdValid` sampled in cycle k (k ≥ 2) → WRITE in cycle k+1 → `Hi`/`Lo` show the new value from cycle k+2, when `Busy`=0.
- **Back-to-back:** earliest next `MulAck` is cycle k+2.
- **Read latency:** 1 cycle. Accepted in cycle n → `RdValid`=1 and `RdData` valid in cycle n+1, for one cycle.
- **Timeout:** with no `ProdValid`, `Timeout` rises `LATENCY`+2 cycles after acceptance.

## Configuration
- **`MADD_EN`:**
  - Defined: `Acc` is latched at acceptance.
  - In WRITE, `{Hi,Lo}` ← `{Hi,Lo}` + holding register when `Acc` was latched, else the holding register alone.
  - Undefined: `Acc` is ignored, no adder is built, and WRITE always loads the product.

## Test plan
- **Reset:** assert `RST` mid-WAIT → next cycle `Busy`=0, `MulStart`=0, `Hi`=`Lo`=0, `Timeout`=0.
- **Basic multiply:** `MulReq` in cycle 0; `ProdValid` in cycle 10 with `Product`=64'hFFFFFFFF_FFFFFFFA (−6) → `MulStart` only in cycle 1; in cycle 12 `Hi`=32'hFFFFFFFF, `Lo`=32'hFFFFFFFA, `Busy`=0.
- **Stalled read:** `RdLo` held from cycle 3 during the above → `Stall`=1 through cycle 11; accepted in cycle 12; `RdData`=32'hFFFFFFFA with `RdValid` in cycle 13.
- **Moves:** `MtHi`, `MtLo` with `WrData`=32'h12345678 in IDLE, then `RdHi` → `RdData`=32'h12345678. Same move during WAIT → `Stall`=1 and `Hi` unchanged.
- **Timeout:** `LATENCY`=8, `ProdValid` never asserted → `Timeout`=1 in cycle 10, state IDLE, `Hi`/`Lo` unchanged. A subsequent multiply completes normally and `Timeout` stays 1.
- **Accumulate (`MADD_EN`):** `{Hi,Lo}`=64'h0000_0001_FFFF_FFFF, `Acc`=1, `Product`=1 → `{Hi,Lo}`=64'h0000_0002_0000_0000. With `MADD_EN` undefined → `{Hi,Lo}`=1.
